// File: rtl/axi_slv_pkg.sv
// Shared types and sizing helpers for the AXI slave write-frame splitter.
package axi_slv_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wst_e;

    // {last, addr, strb, data}
    function automatic int frame_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w / 8 + data_w;
    endfunction

    function automatic int slices(input int axi_dw, input int frame_dw);
        return axi_dw / frame_dw;
    endfunction

endpackage

// File: rtl/axi_aw_fifo.sv
// Synchronous FIFO holding accepted AW commands until the write FSM picks them up.
module axi_aw_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp_q, rp_q;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = (wp_q == rp_q);
    assign full_o  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign dout_o  = mem[rp_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (push_i && !full_o) wp_q <= wp_q + 1'b1;
            if (pop_i && !empty_o) rp_q <= rp_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !full_o) mem[wp_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/axi_slv_wframe_split.sv
// AXI INCR write front end: queues AW, splits each W beat into arbiter frames, returns B with ID echo.
module axi_slv_wframe_split
    import axi_slv_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 256,
    parameter int AXI_ADDR_WIDTH = 25,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int FRAME_DATA_W   = 64,
    parameter int AW_FIFO_DEPTH  = 4,
    parameter int SKIP_EMPTY     = 1
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            axi_s_awvalid,
    output logic                                            axi_s_awready,
    input  logic [AXI_ID_WIDTH-1:0]                         axi_s_awid,
    input  logic [AXI_ADDR_WIDTH-1:0]                       axi_s_awaddr,
    input  logic [7:0]                                      axi_s_awlen,
    input  logic                                            axi_s_wvalid,
    output logic                                            axi_s_wready,
    input  logic [AXI_DATA_WIDTH-1:0]                       axi_s_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]                     axi_s_wstrb,
    input  logic                                            axi_s_wlast,
    output logic                                            axi_s_bvalid,
    input  logic                                            axi_s_bready,
    output logic [AXI_ID_WIDTH-1:0]                         axi_s_bid,
    output logic [1:0]                                      axi_s_bresp,
    output logic                                            axi2arb_wframe_valid,
    input  logic                                            axi2arb_wframe_ready,
    output logic [frame_w(AXI_ADDR_WIDTH, FRAME_DATA_W)-1:0] axi2arb_wframe_data
);
    localparam int SLICES = slices(AXI_DATA_WIDTH, FRAME_DATA_W);
    localparam int SW     = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int FB     = FRAME_DATA_W / 8;
    localparam int BEAT_B = AXI_DATA_WIDTH / 8;
    localparam int QW     = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 8;

    wst_e                       state_q, state_d;
    logic                       awrdy_q;
    logic [AXI_ADDR_WIDTH-1:0]  addr_q;
    logic [7:0]                 len_q, cnt_q;
    logic [AXI_ID_WIDTH-1:0]    id_q, bid_q;
    logic                       err_q, bv_q;
    resp_e                      bresp_q;
    logic [SW-1:0]              slice_q;
    logic [AXI_DATA_WIDTH-1:0]  data_q;
    logic [BEAT_B-1:0]          strb_q;

    logic                       q_full, q_empty, q_pop, q_push;
    logic [QW-1:0]              q_dout;
    logic [AXI_ID_WIDTH-1:0]    q_id;
    logic [AXI_ADDR_WIDTH-1:0]  q_addr;
    logic [7:0]                 q_len;

    logic [FB-1:0]              cur_strb;
    logic [FRAME_DATA_W-1:0]    cur_data;
    logic [AXI_ADDR_WIDTH-1:0]  frm_addr;
    logic                       last_beat, last_slice, frm_last, skip, adv, w_hs;

    // awready is held low until the first clock after reset releases.
    assign axi_s_awready = awrdy_q && !q_full;
    assign q_push        = axi_s_awvalid && axi_s_awready;
    assign {q_id, q_addr, q_len} = q_dout;

    axi_aw_fifo #(.W(QW), .DEPTH(AW_FIFO_DEPTH)) u_aw_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (q_push),
        .din_i   ({axi_s_awid, axi_s_awaddr, axi_s_awlen}),
        .pop_i   (q_pop),
        .dout_o  (q_dout),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    assign cur_strb   = strb_q[int'(slice_q)*FB +: FB];
    assign cur_data   = data_q[int'(slice_q)*FRAME_DATA_W +: FRAME_DATA_W];
    assign frm_addr   = addr_q + AXI_ADDR_WIDTH'(int'(slice_q) * FB);
    assign last_beat  = (cnt_q == len_q);
    assign last_slice = (slice_q == SW'(SLICES - 1));
    assign frm_last   = last_beat && last_slice;
    // The burst's final slice always goes out so the arbiter sees the last marker.
    assign skip       = (SKIP_EMPTY != 0) && (cur_strb == '0) && !frm_last;
    assign axi2arb_wframe_valid = (state_q == W_DATA) && bv_q && !skip;
    assign axi2arb_wframe_data  = axi2arb_wframe_valid ? {frm_last, frm_addr, cur_strb, cur_data} : '0;
    assign adv        = (state_q == W_DATA) && bv_q && (skip || axi2arb_wframe_ready);
    assign w_hs       = axi_s_wvalid && axi_s_wready;
    assign axi_s_bid   = bid_q;
    assign axi_s_bresp = bresp_q;

    always_comb begin
        state_d      = state_q;
        q_pop        = 1'b0;
        axi_s_wready = 1'b0;
        axi_s_bvalid = 1'b0;
        unique case (state_q)
            W_IDLE: if (!q_empty) begin
                q_pop   = 1'b1;
                state_d = W_DATA;
            end
            W_DATA: begin
                axi_s_wready = !bv_q;
                if (adv && frm_last) state_d = W_RESP;
            end
            W_RESP: begin
                axi_s_bvalid = 1'b1;
                if (axi_s_bready) state_d = W_IDLE;
            end
            default: state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= W_IDLE;
            awrdy_q <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            id_q    <= '0;
            err_q   <= 1'b0;
            bv_q    <= 1'b0;
            slice_q <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            bid_q   <= '0;
            bresp_q <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            awrdy_q <= 1'b1;
            if (q_pop) begin
                addr_q <= q_addr & ~AXI_ADDR_WIDTH'(BEAT_B - 1);
                len_q  <= q_len;
                id_q   <= q_id;
                cnt_q  <= '0;
                err_q  <= 1'b0;
            end
            if (w_hs) begin
                data_q  <= axi_s_wdata;
                strb_q  <= axi_s_wstrb;
                bv_q    <= 1'b1;
                slice_q <= '0;
                if (axi_s_wlast != last_beat) err_q <= 1'b1;
            end
            if (adv) begin
                if (last_slice) begin
                    bv_q    <= 1'b0;
                    slice_q <= '0;
                    addr_q  <= addr_q + AXI_ADDR_WIDTH'(BEAT_B);
                    cnt_q   <= cnt_q + 8'd1;
                end else begin
                    slice_q <= slice_q + 1'b1;
                end
            end
            if (state_q == W_DATA && state_d == W_RESP) begin
                bid_q   <= id_q;
                bresp_q <= err_q ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

endmodule

// File: tb/tb_axi_slv_wframe_split.sv
// Directed bench: table of bursts with hand-computed frames, plus queue-depth and reset sequences.
module tb_axi_slv_wframe_split;

    localparam int FW = 98;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          awvalid = 1'b0, awready;
    logic [3:0]    awid = '0;
    logic [24:0]   awaddr = '0;
    logic [7:0]    awlen = '0;
    logic          wvalid = 1'b0, wready, wlast = 1'b0;
    logic [255:0]  wdata = '0;
    logic [31:0]   wstrb = '0;
    logic          bvalid, bready = 1'b1;
    logic [3:0]    bid;
    logic [1:0]    bresp;
    logic          fvalid, fready = 1'b1;
    logic [FW-1:0] fdata;

    int checks = 0;
    int errors = 0;
    logic          stall_mode = 1'b0;
    logic          st_pend = 1'b0;
    logic [FW-1:0] st_data;
    logic [FW-1:0] fq[$];
    logic [5:0]    bq[$];

    typedef struct packed {
        logic [3:0]        id;
        logic [24:0]       addr;
        logic [7:0]        len;
        logic [31:0]       strb;
        int                wl;
        logic              stall;
        int                n;
        logic [0:7][24:0]  ea;
        logic [0:7][7:0]   es;
        logic [1:0]        br;
    } vec_t;

    vec_t vt[7];

    always #5 clk = ~clk;

    axi_slv_wframe_split dut (
        .clk(clk), .rst(rst),
        .axi_s_awvalid(awvalid), .axi_s_awready(awready), .axi_s_awid(awid),
        .axi_s_awaddr(awaddr), .axi_s_awlen(awlen),
        .axi_s_wvalid(wvalid), .axi_s_wready(wready), .axi_s_wdata(wdata),
        .axi_s_wstrb(wstrb), .axi_s_wlast(wlast),
        .axi_s_bvalid(bvalid), .axi_s_bready(bready), .axi_s_bid(bid), .axi_s_bresp(bresp),
        .axi2arb_wframe_valid(fvalid), .axi2arb_wframe_ready(fready),
        .axi2arb_wframe_data(fdata)
    );

    function automatic logic [63:0] pat(input logic [3:0] id, input logic [24:0] a);
        return {16'hD00D, 4'h0, id, 15'h0, a};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Frame ready: constant 1, or toggling every cycle in stall mode.
    initial forever begin
        @(posedge clk); #1;
        fready = stall_mode ? ~fready : 1'b1;
    end

    always @(negedge clk) begin
        if (rst) st_pend = 1'b0;
        else begin
            if (st_pend) chk("stall_hold", 128'({fvalid, fdata}), 128'({1'b1, st_data}));
            st_pend = fvalid && !fready;
            st_data = fdata;
            if (fvalid && fready) fq.push_back(fdata);
            if (bvalid && bready) bq.push_back({bid, bresp});
        end
    end

    // All driving tasks start and end one time unit after a rising edge.
    task automatic send_aw(input logic [3:0] id, input logic [24:0] a, input logic [7:0] l);
        int n = 0;
        awvalid = 1'b1; awid = id; awaddr = a; awlen = l;
        @(negedge clk);
        while (!awready && n < 300) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        awvalid = 1'b0;
        if (n >= 300) chk("awready_timeout", 128'(awready), 128'(1));
    endtask

    task automatic send_beat(input logic [3:0] id, input logic [24:0] a, input int b,
                             input logic [31:0] strb, input logic last);
        int n = 0;
        logic [24:0] ba;
        ba = (a & ~25'h1F) + 25'(b * 32);
        for (int s = 0; s < 4; s++) wdata[s*64 +: 64] = pat(id, ba + 25'(s * 8));
        wstrb = strb; wlast = last; wvalid = 1'b1;
        @(negedge clk);
        while (!wready && n < 300) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        wvalid = 1'b0; wlast = 1'b0;
        if (n >= 300) chk("wready_timeout", 128'(wready), 128'(1));
    endtask

    task automatic wait_b(input int k);
        int n = 0;
        while (bq.size() < k && n < 2000) begin @(posedge clk); #1; n++; end
        if (n >= 2000) chk("bvalid_timeout", 128'(bq.size()), 128'(k));
    endtask

    task automatic run_vec(input int vi, input vec_t v);
        fq.delete(); bq.delete();
        stall_mode = v.stall;
        send_aw(v.id, v.addr, v.len);
        for (int b = 0; b <= int'(v.len); b++) send_beat(v.id, v.addr, b, v.strb, b == v.wl);
        wait_b(1);
        stall_mode = 1'b0;
        chk($sformatf("v%0d_frame_count", vi), 128'(fq.size()), 128'(v.n));
        for (int i = 0; i < v.n && i < fq.size(); i++)
            chk($sformatf("v%0d_frame%0d", vi, i), 128'(fq[i]),
                128'({(i == v.n - 1), v.ea[i], v.es[i], pat(v.id, v.ea[i])}));
        if (bq.size() > 0) chk($sformatf("v%0d_bid_bresp", vi), 128'(bq[0]), 128'({v.id, v.br}));
    endtask

    initial begin
        vt[0] = '{4'd3, 25'h40, 8'd1, 32'hFFFF_FFFF, 1, 1'b0, 8,
                  {25'h40, 25'h48, 25'h50, 25'h58, 25'h60, 25'h68, 25'h70, 25'h78},
                  {8{8'hFF}}, 2'b00};
        vt[1] = '{4'd5, 25'h100, 8'd0, 32'hFFFF_00FF, 0, 1'b0, 3,
                  {25'h100, 25'h110, 25'h118, 25'h0, 25'h0, 25'h0, 25'h0, 25'h0},
                  {8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2'b00};
        vt[2] = '{4'd6, 25'h200, 8'd1, 32'hFFFF_FFFF, 1, 1'b1, 8,
                  {25'h200, 25'h208, 25'h210, 25'h218, 25'h220, 25'h228, 25'h230, 25'h238},
                  {8{8'hFF}}, 2'b00};
        vt[3] = '{4'd7, 25'h300, 8'd2, 32'h0000_00FF, 0, 1'b0, 4,
                  {25'h300, 25'h320, 25'h340, 25'h358, 25'h0, 25'h0, 25'h0, 25'h0},
                  {8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2'b10};
        vt[4] = '{4'd8, 25'h400, 8'd0, 32'hFFFF_FFFF, 0, 1'b0, 4,
                  {25'h400, 25'h408, 25'h410, 25'h418, 25'h0, 25'h0, 25'h0, 25'h0},
                  {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00}, 2'b00};
        vt[5] = '{4'd9, 25'h1FF_FFE0, 8'd1, 32'hFFFF_FFFF, 1, 1'b0, 8,
                  {25'h1FF_FFE0, 25'h1FF_FFE8, 25'h1FF_FFF0, 25'h1FF_FFF8,
                   25'h0, 25'h8, 25'h10, 25'h18},
                  {8{8'hFF}}, 2'b00};
        vt[6] = '{4'd10, 25'h45, 8'd0, 32'hFF00_0000, 0, 1'b0, 1,
                  {25'h58, 25'h0, 25'h0, 25'h0, 25'h0, 25'h0, 25'h0, 25'h0},
                  {8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2'b00};

        // Reset state
        @(negedge clk);
        chk("reset_ctrl", 128'({awready, wready, bvalid, fvalid}), 128'(0));
        chk("reset_data", 128'({bid, bresp, fdata}), 128'(0));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("awready_after_reset", 128'({awready, wready}), 128'(2'b10));

        for (int i = 0; i < 7; i++) run_vec(i, vt[i]);

        // Queue depth: five AWs with W held off fill the queue behind the active burst.
        fq.delete(); bq.delete();
        for (int i = 0; i < 5; i++) send_aw(4'(i), 25'(32'h800 + i * 32'h100), 8'd0);
        @(negedge clk);
        chk("awready_full", 128'(awready), 128'(0));
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) send_beat(4'(i), 25'(32'h800 + i * 32'h100), 0, 32'hFFFF_FFFF, 1'b1);
        wait_b(5);
        chk("queue_frame_count", 128'(fq.size()), 128'(20));
        for (int i = 0; i < 5 && i < bq.size(); i++)
            chk($sformatf("queue_bid%0d", i), 128'(bq[i]), 128'({4'(i), 2'b00}));

        // Reset mid-burst
        fq.delete(); bq.delete();
        send_aw(4'd1, 25'h500, 8'd1);
        send_beat(4'd1, 25'h500, 0, 32'hFFFF_FFFF, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_ctrl", 128'({awready, wready, bvalid, fvalid}), 128'(0));
        chk("midrst_data", 128'({bid, bresp, fdata}), 128'(0));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_awready", 128'({awready, bvalid}), 128'(2'b10));
        chk("midrst_no_b", 128'(bq.size()), 128'(0));
        run_vec(7, vt[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
